// File: rtl/tl_pkg.sv
// Shared TileLink D-channel types: response opcodes, the default D-beat layout
// and the response arbiter's state encoding.
package tl_pkg;

    typedef enum logic [2:0] {
        AccessAck     = 3'd0,
        AccessAckData = 3'd1,
        HintAck       = 3'd2,
        Grant         = 3'd4,
        GrantData     = 3'd5,
        ReleaseAck    = 3'd6
    } tl_d_opcode_e;

    typedef enum logic {
        IDLE,
        BURST
    } tl_d_arb_state_e;

    // size is log2 of the transfer length in bytes
    typedef struct packed {
        tl_d_opcode_e opcode;
        logic [3:0]   size;
        logic [3:0]   source;
        logic [63:0]  data;
    } tl_d_beat_t;

endpackage

// File: rtl/tl_rr_pick.sv
// Combinational round-robin picker: grants the first requester found when
// scanning upwards from ptr, wrapping around at N.
module tl_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = IDX_W'((int'(ptr) + k) % N);
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/tl_d_resp_arbiter.sv
// TileLink D-channel response arbiter: round-robin merge of SLAVE_NUM slave
// D ports onto one registered master D port, holding the grant for bursts.
module tl_d_resp_arbiter
    import tl_pkg::*;
#(
    parameter int  SLAVE_NUM  = 2,
    parameter type DATA_T     = tl_d_beat_t,
    parameter int  BEAT_BYTES = 8,
    parameter int  MAX_SIZE   = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  DATA_T [SLAVE_NUM-1:0] inp_bits_i,
    input  logic [SLAVE_NUM-1:0]  inp_valid_i,
    output logic [SLAVE_NUM-1:0]  inp_ready_o,
    output logic                  oup_valid_o,
    output DATA_T                 oup_bits_o,
    input  logic                  oup_ready_i,
    output logic                  busy_o
);

    localparam int LOG2_BEAT = $clog2(BEAT_BYTES);
    localparam int IDX_W     = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;
    localparam int CNT_W     = (MAX_SIZE > LOG2_BEAT) ? (MAX_SIZE - LOG2_BEAT + 1) : 1;
    localparam logic [SLAVE_NUM-1:0] ONE = {{(SLAVE_NUM-1){1'b0}}, 1'b1};

    tl_d_arb_state_e      state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     lock_idx_q, lock_idx_d;
    logic [CNT_W-1:0]     beats_left_q, beats_left_d;
    logic                 oup_valid_q, oup_valid_d;
    DATA_T                oup_bits_q, oup_bits_d;

    logic [SLAVE_NUM-1:0] eligible;
    logic [SLAVE_NUM-1:0] grant;
    logic [IDX_W-1:0]     win;
    logic                 any_req;
    logic                 can_load;
    logic                 accept;
    logic                 multibeat;
    DATA_T                win_bits;
    int                   size_c;
    logic [CNT_W-1:0]     nbeats_m1;

    assign can_load = !oup_valid_q || oup_ready_i;
    assign eligible = (state_q == BURST) ? (inp_valid_i & (ONE << lock_idx_q)) : inp_valid_i;

    tl_rr_pick #(
        .N     (SLAVE_NUM),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (eligible),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (win),
        .any   (any_req)
    );

    // Ready is withheld while reset is asserted so no slave sees a phantom handshake.
    assign inp_ready_o = (can_load && rst_i) ? grant : '0;
    assign accept      = can_load && any_req;

    always_comb begin
        win_bits = inp_bits_i[win];
        size_c   = int'(win_bits.size);
        if (size_c > MAX_SIZE) begin
            size_c = MAX_SIZE;
        end
        multibeat = (win_bits.opcode == AccessAckData) && (size_c > LOG2_BEAT);
        nbeats_m1 = multibeat ? CNT_W'((1 << (size_c - LOG2_BEAT)) - 1) : '0;
    end

    // The pointer advances only on message heads, so a burst never costs its owner fairness.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lock_idx_d   = lock_idx_q;
        beats_left_d = beats_left_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    rr_ptr_d = (win == IDX_W'(SLAVE_NUM - 1)) ? '0 : (win + IDX_W'(1));
                    if (multibeat) begin
                        state_d      = BURST;
                        lock_idx_d   = win;
                        beats_left_d = nbeats_m1;
                    end
                end
                BURST: begin
                    beats_left_d = beats_left_q - CNT_W'(1);
                    if (beats_left_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        oup_valid_d = oup_valid_q;
        oup_bits_d  = oup_bits_q;
        if (can_load) begin
            oup_valid_d = accept;
            if (accept) begin
                oup_bits_d = win_bits;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            lock_idx_q   <= '0;
            beats_left_q <= '0;
            oup_valid_q  <= 1'b0;
            oup_bits_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_idx_q   <= lock_idx_d;
            beats_left_q <= beats_left_d;
            oup_valid_q  <= oup_valid_d;
            oup_bits_q   <= oup_bits_d;
        end
    end

    assign oup_valid_o = oup_valid_q;
    assign oup_bits_o  = oup_bits_q;
    assign busy_o      = (state_q == BURST);

endmodule
